// File: rtl/reg_bus_pkg.sv
// Shared definitions for the peripheral register bus master: access sizes,
// FSM states, register offsets and the request alignment check.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_RSV = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] REG_CNAME    = 3'd0;
    localparam logic [2:0] REG_CVERSION = 3'd1;
    localparam logic [2:0] REG_TRISTATE = 3'd2;
    localparam logic [2:0] REG_PINSTATE = 3'd3;
    localparam logic [2:0] REG_IRQMASK  = 3'd4;
    localparam logic [2:0] REG_DATAREG  = 3'd5;
    localparam logic [2:0] REG_SCRATCH  = 3'd6;

    // Reserved size counts as misaligned so every illegal request funnels into one error path.
    function automatic logic misaligned(input size_t size, input logic [1:0] byte_off);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = byte_off[0];
            SIZE_W:  bad = |byte_off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// extraction with sign or zero extension.
module bus_lane_align
    import reg_bus_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  byte_off,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wben,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        wben  = '0;
        wdata = '0;
        case (size)
            SIZE_B: begin
                wben  = 4'b0001 << byte_off;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                wben  = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            SIZE_W: begin
                wben  = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wben  = '0;
                wdata = '0;
            end
        endcase
    end

    always_comb begin
        shifted   = rdata >> {byte_off, 3'b000};
        load_data = shifted;
        case (size)
            SIZE_B:  load_data = load_unsigned ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_data = load_unsigned ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/reg_bus_master.sv
// Register bus initiator: accepts LSU load/store requests, runs one bus access
// per request and returns a single-cycle response.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int unsigned READ_LATENCY = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [2:0]  bus_addr,
    output logic [3:0]  bus_wben,
    output logic        bus_r_wn,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t      state, state_next;
    logic [4:0]  addr_q;
    size_t       size_q;
    logic        we_q;
    logic        unsigned_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  cnt;

    logic        accept;
    logic        req_err;
    logic [3:0]  lane_wben;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_err = (req_addr[31:5] != BASE_ADDR[31:5])
               || misaligned(size_t'(req_size), req_addr[1:0]);
    end

    bus_lane_align u_lane_align (
        .size          (size_q),
        .byte_off      (addr_q[1:0]),
        .load_unsigned (unsigned_q),
        .store_data    (wdata_q),
        .rdata         (bus_rdata),
        .wben          (lane_wben),
        .wdata         (lane_wdata),
        .load_data     (lane_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)     state_next = RESP;
                    else if (req_we) state_next = WRITE;
                    else             state_next = READ;
                end
            end
            READ:    if (cnt == LAT) state_next = RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= SIZE_B;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
        end else if (accept) begin
            addr_q     <= req_addr[4:0];
            size_q     <= size_t'(req_size);
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            err_q      <= req_err;
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
            cnt        <= '0;
        end else if (state == READ) begin
            // Slave data is valid on the last READ cycle; capture it extended.
            if (cnt == LAT) rdata_q <= lane_load;
            else            cnt     <= cnt + 3'd1;
        end
    end

    always_comb begin
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = (state == RESP) ? rdata_q : '0;
        bus_addr   = (state == READ || state == WRITE) ? addr_q[4:2] : '0;
        bus_r_wn   = (state != WRITE);
        bus_wben   = (state == WRITE) ? lane_wben  : '0;
        bus_wdata  = (state == WRITE) ? lane_wdata : '0;
    end

    // we_q is only informative once the state already encodes the direction.
    logic unused_ok;
    assign unused_ok = we_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master against a small peripheral register block model.
module tb_reg_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [2:0]  bus_addr;
    logic [3:0]  bus_wben;
    logic        bus_r_wn;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bus_master #(
        .BASE_ADDR    (32'h4000_0000),
        .READ_LATENCY (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .bus_addr     (bus_addr),
        .bus_wben     (bus_wben),
        .bus_r_wn     (bus_r_wn),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata)
    );

    // Peripheral register block: CNAME read-only constant, others plain byte-writable.
    logic [31:0] regs [8];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            bus_rdata <= '0;
        end else begin
            if (!bus_r_wn && bus_addr != 3'd0) begin
                for (int b = 0; b < 4; b++)
                    if (bus_wben[b]) regs[bus_addr][8*b +: 8] <= bus_wdata[8*b +: 8];
            end
            bus_rdata <= (bus_addr == 3'd0) ? 32'h4852_4A44 : regs[bus_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the most recent transaction.
    int          lat, wr_cycles, wr_at;
    logic        r_err, wben_leak;
    logic [31:0] r_data, wr_wdata;
    logic [3:0]  wr_wben;
    logic [2:0]  wr_addr;

    // Called at #1 after a posedge with the DUT idle; returns one cycle after the response.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] d);
        logic got;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; wr_cycles = 0; wr_at = 0; wben_leak = 1'b0; got = 1'b0;
        r_err = 1'b0; r_data = '0; wr_wben = '0; wr_wdata = '0; wr_addr = '0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (!bus_r_wn) begin
                wr_cycles++; wr_at = i;
                wr_addr = bus_addr; wr_wben = bus_wben; wr_wdata = bus_wdata;
            end
            if (bus_r_wn && bus_wben != 4'd0) wben_leak = 1'b1;
            if (resp_valid) begin
                got = 1'b1; lat = i; r_err = resp_err; r_data = resp_rdata;
            end
            @(posedge clk); #1;
        end
        if (!got) check_eq("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] exp);
        run_req(1'b0, addr, size, uns, 32'h0);
        check_eq({tag, "_data"}, r_data, exp);
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
        check_eq({tag, "_err"}, {31'd0, r_err}, 32'd0);
        check_eq({tag, "_nowr"}, 32'(wr_cycles), 32'd0);
    endtask

    task automatic store_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] d, input logic [2:0] exp_addr,
                             input logic [3:0] exp_wben, input logic [31:0] exp_wdata);
        run_req(1'b1, addr, size, 1'b0, d);
        check_eq({tag, "_lat"}, 32'(lat), 32'd2);
        check_eq({tag, "_err"}, {31'd0, r_err}, 32'd0);
        check_eq({tag, "_rdata"}, r_data, 32'd0);
        check_eq({tag, "_wrcyc"}, 32'(wr_cycles), 32'd1);
        check_eq({tag, "_wrat"}, 32'(wr_at), 32'd1);
        check_eq({tag, "_addr"}, {29'd0, wr_addr}, {29'd0, exp_addr});
        check_eq({tag, "_wben"}, {28'd0, wr_wben}, {28'd0, exp_wben});
        check_eq({tag, "_wdata"}, wr_wdata, exp_wdata);
    endtask

    task automatic err_chk(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] size);
        run_req(we, addr, size, 1'b0, 32'hFFFF_FFFF);
        check_eq({tag, "_lat"}, 32'(lat), 32'd1);
        check_eq({tag, "_err"}, {31'd0, r_err}, 32'd1);
        check_eq({tag, "_rdata"}, r_data, 32'd0);
        check_eq({tag, "_nowr"}, 32'(wr_cycles), 32'd0);
        check_eq({tag, "_wben"}, {31'd0, wben_leak}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] d;
    } req_t;

    initial begin
        req_t seq [5];
        int   acc [5];
        int   idx, cyc;
        logic bad;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_bus_addr", {29'd0, bus_addr}, 32'd0);
        check_eq("rst_bus_wben", {28'd0, bus_wben}, 32'd0);
        check_eq("rst_bus_r_wn", {31'd0, bus_r_wn}, 32'd1);
        check_eq("rst_bus_wdata", bus_wdata, 32'd0);

        store_chk("sw_scratch", 32'h4000_0018, 2'd2, 32'hDEAD_BEEF, 3'd6, 4'b1111, 32'hDEAD_BEEF);
        load_chk("lw_scratch", 32'h4000_0018, 2'd2, 1'b0, 32'hDEAD_BEEF);

        store_chk("sb_data", 32'h4000_0015, 2'd0, 32'h0000_00A5, 3'd5, 4'b0010, 32'hA5A5_A5A5);
        load_chk("lw_data", 32'h4000_0014, 2'd2, 1'b0, 32'h0000_A500);
        store_chk("sh_data", 32'h4000_0016, 2'd1, 32'hCAFE_1234, 3'd5, 4'b1100, 32'h1234_1234);
        load_chk("lw_data2", 32'h4000_0014, 2'd2, 1'b0, 32'h1234_A500);

        load_chk("lw_cname", 32'h4000_0000, 2'd2, 1'b0, 32'h4852_4A44);
        load_chk("lbu_cname", 32'h4000_0003, 2'd0, 1'b1, 32'h0000_0048);
        load_chk("lhu_cname", 32'h4000_0002, 2'd1, 1'b1, 32'h0000_4852);
        load_chk("lb_cname1", 32'h4000_0001, 2'd0, 1'b0, 32'h0000_004A);

        store_chk("sw_scr2", 32'h4000_0018, 2'd2, 32'h0000_80FF, 3'd6, 4'b1111, 32'h0000_80FF);
        load_chk("lb_scr", 32'h4000_0018, 2'd0, 1'b0, 32'hFFFF_FFFF);
        load_chk("lbu_scr", 32'h4000_0018, 2'd0, 1'b1, 32'h0000_00FF);
        load_chk("lh_scr", 32'h4000_0018, 2'd1, 1'b0, 32'hFFFF_80FF);
        load_chk("lhu_scr", 32'h4000_0018, 2'd1, 1'b1, 32'h0000_80FF);
        load_chk("lb_scr1", 32'h4000_0019, 2'd0, 1'b0, 32'hFFFF_FF80);

        err_chk("err_lw_mis", 1'b0, 32'h4000_0002, 2'd2);
        err_chk("err_sh_mis", 1'b1, 32'h4000_0019, 2'd1);
        err_chk("err_size3", 1'b0, 32'h4000_0018, 2'd3);
        err_chk("err_window", 1'b0, 32'h5000_0000, 2'd2);
        err_chk("err_sw_win", 1'b1, 32'h5000_0018, 2'd2);
        load_chk("lw_after_err", 32'h4000_0018, 2'd2, 1'b0, 32'h0000_80FF);

        // Back-to-back: req_valid held high, next request presented right after each accept.
        seq[0] = '{1'b1, 32'h4000_0010, 2'd2, 32'h1111_1111};
        seq[1] = '{1'b1, 32'h4000_0014, 2'd2, 32'h2222_2222};
        seq[2] = '{1'b1, 32'h4000_0018, 2'd2, 32'h3333_3333};
        seq[3] = '{1'b0, 32'h4000_0010, 2'd2, 32'h0};
        seq[4] = '{1'b0, 32'h4000_0018, 2'd2, 32'h0};
        idx = 0; cyc = 0;
        req_valid = 1'b1; req_we = seq[0].we; req_addr = seq[0].addr;
        req_size = seq[0].size; req_unsigned = 1'b0; req_wdata = seq[0].d;
        while (idx < 5 && cyc < 60) begin
            bad = req_ready;
            if (bad) begin
                acc[idx] = cyc;
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
            if (bad) begin
                if (idx < 5) begin
                    req_we = seq[idx].we; req_addr = seq[idx].addr;
                    req_size = seq[idx].size; req_wdata = seq[idx].d;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check_eq("b2b_count", 32'(idx), 32'd5);
        if (idx == 5) begin
            check_eq("b2b_acc1", 32'(acc[1] - acc[0]), 32'd3);
            check_eq("b2b_acc2", 32'(acc[2] - acc[0]), 32'd6);
            check_eq("b2b_acc3", 32'(acc[3] - acc[0]), 32'd9);
            check_eq("b2b_acc4", 32'(acc[4] - acc[0]), 32'd13);
        end
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("b2b_idle", {31'd0, req_ready}, 32'd1);
        load_chk("b2b_rd_dreg", 32'h4000_0014, 2'd2, 1'b0, 32'h2222_2222);

        // Reset during the READ cycle aborts the load.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0018; req_size = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("abort_in_read", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_rst_resp", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid || !bus_r_wn) bad = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("abort_quiet", {31'd0, bad}, 32'd0);

        // Reset also clears the slave, so a store still works cleanly afterwards.
        store_chk("post_rst_sw", 32'h4000_0004, 2'd2, 32'h0BAD_F00D, 3'd1, 4'b1111, 32'h0BAD_F00D);
        load_chk("post_rst_lw", 32'h4000_0004, 2'd2, 1'b0, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
